// File: rtl/scpu_pkg.sv
// Shared definitions for the register/ALU datapath: widths, ALU opcodes, status-word layout.
package scpu_pkg;

    localparam int unsigned DEF_NREGS = 8;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned OPW       = 4;

    typedef enum logic [OPW-1:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBB = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_CMP = 4'd7,
        ALU_INC = 4'd8,
        ALU_DEC = 4'd9,
        ALU_NOT = 4'd10,
        ALU_SHL = 4'd11,
        ALU_SHR = 4'd12,
        ALU_ROL = 4'd13,
        ALU_ROR = 4'd14,
        ALU_NOP = 4'd15
    } alu_op_e;

    localparam int unsigned SW_Z  = 7;
    localparam int unsigned SW_E  = 6;
    localparam int unsigned SW_GT = 5;
    localparam int unsigned SW_LT = 4;
    localparam int unsigned SW_CF = 3;

    // Field order matches the status-word bit indices above.
    typedef struct packed {
        logic       z;
        logic       e;
        logic       gt;
        logic       lt;
        logic       cf;
        logic [2:0] rsvd;
    } status_t;

endpackage

// File: rtl/reg_alu_datapath_if.sv
// Control-unit <-> datapath bundle: register/ALU selects, shared data and address buses, status.
interface reg_alu_datapath_if
    import scpu_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned DW    = DEF_DW
);
    localparam int unsigned AW = 2 * DW;

    logic [NREGS-1:0] regs_rdata;
    logic [NREGS-1:0] regs_wdata;
    logic [NREGS-1:0] regs_raddr;
    logic [NREGS-1:0] regs_waddr;
    logic [NREGS-1:0] regs_alu_r_a;
    logic [NREGS-1:0] regs_alu_r_b;
    logic [NREGS-1:0] regs_alu_w;
    logic [OPW-1:0]   alu_opr;
    logic             alu_en;
    logic             alu_direct_data_bus_en;
    logic [DW-1:0]    data_bus_in;
    logic [DW-1:0]    data_bus_out;
    logic             data_bus_oe;
    logic [AW-1:0]    addr_bus_in;
    logic [AW-1:0]    addr_bus_out;
    logic             addr_bus_oe;
    logic [7:0]       status_word;

    modport master (
        output regs_rdata, regs_wdata, regs_raddr, regs_waddr,
        output regs_alu_r_a, regs_alu_r_b, regs_alu_w,
        output alu_opr, alu_en, alu_direct_data_bus_en,
        output data_bus_in, addr_bus_in,
        input  data_bus_out, data_bus_oe, addr_bus_out, addr_bus_oe, status_word
    );

    modport slave (
        input  regs_rdata, regs_wdata, regs_raddr, regs_waddr,
        input  regs_alu_r_a, regs_alu_r_b, regs_alu_w,
        input  alu_opr, alu_en, alu_direct_data_bus_en,
        input  data_bus_in, addr_bus_in,
        output data_bus_out, data_bus_oe, addr_bus_out, addr_bus_oe, status_word
    );

endinterface

// File: rtl/reg_alu_datapath_alu_core.sv
// Combinational ALU: 9-bit internal arithmetic, next flags and writeback permission.
module alu_core
    import scpu_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic [DW-1:0]  a_i,
    input  logic [DW-1:0]  b_i,
    input  logic [OPW-1:0] op_i,
    input  logic           cf_i,
    output logic [DW-1:0]  result_o,
    output status_t        flags_o,
    output logic           cmp_upd_o,
    output logic           flags_we_o,
    output logic           wb_ok_o
);

    logic [DW:0] res9;
    logic        cf_n;

    // Operation decode; bit DW of res9 carries the carry/borrow for arithmetic ops.
    always_comb begin
        res9       = '0;
        cf_n       = 1'b0;
        cmp_upd_o  = 1'b0;
        flags_we_o = 1'b1;
        wb_ok_o    = 1'b1;
        case (op_i)
            ALU_ADD: begin
                res9 = {1'b0, a_i} + {1'b0, b_i};
                cf_n = res9[DW];
                cmp_upd_o = 1'b1;
            end
            ALU_ADC: begin
                res9 = {1'b0, a_i} + {1'b0, b_i} + (DW+1)'(cf_i);
                cf_n = res9[DW];
                cmp_upd_o = 1'b1;
            end
            ALU_SUB: begin
                res9 = {1'b0, a_i} - {1'b0, b_i};
                cf_n = res9[DW];
                cmp_upd_o = 1'b1;
            end
            ALU_SBB: begin
                res9 = {1'b0, a_i} - {1'b0, b_i} - (DW+1)'(cf_i);
                cf_n = res9[DW];
                cmp_upd_o = 1'b1;
            end
            ALU_AND: begin
                res9 = {1'b0, a_i & b_i};
                cmp_upd_o = 1'b1;
            end
            ALU_OR: begin
                res9 = {1'b0, a_i | b_i};
                cmp_upd_o = 1'b1;
            end
            ALU_XOR: begin
                res9 = {1'b0, a_i ^ b_i};
                cmp_upd_o = 1'b1;
            end
            ALU_CMP: begin
                res9 = {1'b0, a_i} - {1'b0, b_i};
                cf_n = res9[DW];
                cmp_upd_o = 1'b1;
                wb_ok_o = 1'b0;
            end
            ALU_INC: begin
                res9 = {1'b0, a_i} + (DW+1)'(1);
                cf_n = res9[DW];
            end
            ALU_DEC: begin
                res9 = {1'b0, a_i} - (DW+1)'(1);
                cf_n = res9[DW];
            end
            ALU_NOT: begin
                res9 = {1'b0, ~a_i};
            end
            ALU_SHL: begin
                res9 = {1'b0, a_i[DW-2:0], 1'b0};
                cf_n = a_i[DW-1];
            end
            ALU_SHR: begin
                res9 = {2'b00, a_i[DW-1:1]};
                cf_n = a_i[0];
            end
            ALU_ROL: begin
                res9 = {1'b0, a_i[DW-2:0], a_i[DW-1]};
                cf_n = a_i[DW-1];
            end
            ALU_ROR: begin
                res9 = {1'b0, a_i[0], a_i[DW-1:1]};
                cf_n = a_i[0];
            end
            default: begin
                flags_we_o = 1'b0;
                wb_ok_o    = 1'b0;
            end
        endcase
    end

    // Result and flag packing; E/GT/LT are always computed, the top decides whether to keep them.
    always_comb begin
        result_o      = res9[DW-1:0];
        flags_o.z     = (res9[DW-1:0] == '0);
        flags_o.e     = (a_i == b_i);
        flags_o.gt    = (a_i > b_i);
        flags_o.lt    = (a_i < b_i);
        flags_o.cf    = cf_n;
        flags_o.rsvd  = 3'b000;
    end

endmodule

// File: rtl/reg_alu_datapath.sv
// Register file r0..r7, priority read/write muxes, ALU instance and status-word register.
module reg_alu_datapath
    import scpu_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_alu_datapath_if.slave  bus
);

    localparam int unsigned NPAIRS = NREGS / 2;
    localparam int unsigned AW     = 2 * DW;

    logic [DW-1:0]    regs_q [NREGS];
    logic [DW-1:0]    regs_d [NREGS];
    status_t          status_q;
    status_t          status_d;

    logic [DW-1:0]    rd_data;
    logic [DW-1:0]    opa;
    logic [DW-1:0]    opb_reg;
    logic [DW-1:0]    opb;
    logic [AW-1:0]    pair_data;
    logic [NREGS-1:0] waddr_mask;

    logic [DW-1:0]    alu_result;
    status_t          alu_flags;
    logic             alu_cmp_upd;
    logic             alu_flags_we;
    logic             alu_wb_ok;
    logic             alu_wb;

    // Single-register read muxes; scanning downwards lets the lowest set index win.
    always_comb begin
        rd_data = '0;
        opa     = '0;
        opb_reg = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (bus.regs_rdata[i])   rd_data = regs_q[i];
            if (bus.regs_alu_r_a[i]) opa     = regs_q[i];
            if (bus.regs_alu_r_b[i]) opb_reg = regs_q[i];
        end
    end

    assign opb = bus.alu_direct_data_bus_en ? bus.data_bus_in : opb_reg;

    // Pair read mux and pair write mask; even register is the high byte, lowest pair wins.
    always_comb begin
        pair_data  = '0;
        waddr_mask = '0;
        for (int p = NPAIRS - 1; p >= 0; p--) begin
            if (|bus.regs_raddr[2*p +: 2]) pair_data = {regs_q[2*p], regs_q[2*p+1]};
            if (|bus.regs_waddr[2*p +: 2]) begin
                waddr_mask          = '0;
                waddr_mask[2*p +: 2] = 2'b11;
            end
        end
    end

    alu_core #(.DW(DW)) u_alu (
        .a_i        (opa),
        .b_i        (opb),
        .op_i       (bus.alu_opr),
        .cf_i       (status_q.cf),
        .result_o   (alu_result),
        .flags_o    (alu_flags),
        .cmp_upd_o  (alu_cmp_upd),
        .flags_we_o (alu_flags_we),
        .wb_ok_o    (alu_wb_ok)
    );

    assign alu_wb = bus.alu_en & alu_wb_ok;

    // Register next-state: data bus beats address bus beats ALU writeback.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (bus.regs_wdata[i]) begin
                regs_d[i] = bus.data_bus_in;
            end else if (waddr_mask[i]) begin
                regs_d[i] = ((i % 2) == 0) ? bus.addr_bus_in[AW-1:DW] : bus.addr_bus_in[DW-1:0];
            end else if (alu_wb && bus.regs_alu_w[i]) begin
                regs_d[i] = alu_result;
            end
        end
    end

    // Status next-state; unary ops keep the previous compare flags.
    always_comb begin
        status_d = status_q;
        if (bus.alu_en && alu_flags_we) begin
            status_d = alu_flags;
            if (!alu_cmp_upd) begin
                status_d.e  = status_q.e;
                status_d.gt = status_q.gt;
                status_d.lt = status_q.lt;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            status_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
            status_q <= status_d;
        end
    end

    assign bus.data_bus_out = rd_data;
    assign bus.data_bus_oe  = |bus.regs_rdata;
    assign bus.addr_bus_out = pair_data;
    assign bus.addr_bus_oe  = |bus.regs_raddr;
    assign bus.status_word  = status_q;

endmodule
